// File: rtl/mem_access_ctrl.sv
// Load/store sequencer in front of the word-only MEMSTAGE RAM.
// Adds sub-word loads/stores (read-modify-write) and misalignment flagging.
module mem_access_ctrl #(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        MEM_we,
    output logic [31:0] ALU_MEM_addr,
    output logic [31:0] MEM_datain,
    input  logic [31:0] MEM_dout
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state;
    logic        we_q;
    logic        sgn_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        misaligned;

    function automatic logic [4:0] byte_sh(input logic [1:0] off);
        return BIG_ENDIAN ? {~off, 3'b000} : {off, 3'b000};
    endfunction

    function automatic logic [4:0] half_sh(input logic a1);
        return BIG_ENDIAN ? {~a1, 4'b0000} : {a1, 4'b0000};
    endfunction

    function automatic logic [31:0] extract(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic        sgn,
        input logic [1:0]  off
    );
        logic [31:0] bl;
        logic [31:0] hl;
        logic [31:0] r;
        bl = word >> byte_sh(off);
        hl = word >> half_sh(off[1]);
        case (size)
            2'b00:   r = {{24{sgn & bl[7]}}, bl[7:0]};
            2'b01:   r = {{16{sgn & hl[15]}}, hl[15:0]};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace only the addressed lane of the fetched word
    function automatic logic [31:0] merge(
        input logic [31:0] word,
        input logic [31:0] wdata,
        input logic [1:0]  size,
        input logic [1:0]  off
    );
        logic [31:0] mask;
        logic [31:0] ins;
        case (size)
            2'b00: begin
                mask = 32'h0000_00FF << byte_sh(off);
                ins  = {24'h0, wdata[7:0]} << byte_sh(off);
            end
            2'b01: begin
                mask = 32'h0000_FFFF << half_sh(off[1]);
                ins  = {16'h0, wdata[15:0]} << half_sh(off[1]);
            end
            default: begin
                mask = 32'hFFFF_FFFF;
                ins  = wdata;
            end
        endcase
        return (word & ~mask) | (ins & mask);
    endfunction

    assign misaligned = (req_size == 2'b11)
                      | ((req_size == 2'b01) & req_addr[0])
                      | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));

    assign req_ready    = (state == IDLE);
    assign ALU_MEM_addr = {addr_q[31:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            sgn_q      <= 1'b0;
            size_q     <= 2'b00;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'h0;
            rsp_err    <= 1'b0;
            MEM_we     <= 1'b0;
            MEM_datain <= 32'h0;
        end else begin
            rsp_valid <= 1'b0;
            MEM_we    <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        sgn_q   <= req_signed;
                        size_q  <= req_size;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        if (misaligned) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'h0;
                        end else if (req_we && req_size == 2'b10) begin
                            state      <= WR;
                            MEM_we     <= 1'b1;
                            MEM_datain <= req_wdata;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    if (!we_q) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= extract(MEM_dout, size_q, sgn_q,
                                             addr_q[1:0]);
                    end else begin
                        state      <= WR;
                        MEM_we     <= 1'b1;
                        MEM_datain <= merge(MEM_dout, wdata_q, size_q,
                                            addr_q[1:0]);
                    end
                end
                WR: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= 32'h0;
                end
                default: begin
                    state   <= IDLE;
                    rsp_err <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl (big-endian) with a negedge word RAM.
// Checks data, latency, write-enable pulses, errors and reset abort.
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        MEM_we;
    logic [31:0] ALU_MEM_addr;
    logic [31:0] MEM_datain;
    logic [31:0] MEM_dout;

    logic [31:0] mem [0:255];

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int rsp_cnt = 0;

    mem_access_ctrl #(.BIG_ENDIAN(1'b1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_signed   (req_signed),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .MEM_we       (MEM_we),
        .ALU_MEM_addr (ALU_MEM_addr),
        .MEM_datain   (MEM_datain),
        .MEM_dout     (MEM_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word RAM: read and write on negedge, read returns pre-write contents
    always @(negedge clk) begin
        if (MEM_we) mem[ALU_MEM_addr[9:2]] <= MEM_datain;
        MEM_dout <= mem[ALU_MEM_addr[9:2]];
    end

    always @(negedge clk) begin
        if (MEM_we) we_cnt++;
        if (rsp_valid) rsp_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] size,
                          input logic sgn, input logic [31:0] addr,
                          input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err,
                          output int lat);
        bit got;
        @(negedge clk);
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        got   = 1'b0;
        lat   = 0;
        rdata = 32'hDEAD_BEEF;
        err   = 1'bx;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) begin
                got   = 1'b1;
                rdata = rsp_rdata;
                err   = rsp_err;
            end
        end
        if (!got) lat = -1;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          w0;
    int          r0;
    int          acc;
    int          nrsp;
    int          bad;
    int          nlow;

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b10;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        #12;
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_we", {31'h0, MEM_we}, 32'h0);
        chk("rst_addr", ALU_MEM_addr, 32'h0);
        chk("rst_datain", MEM_datain, 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_err", {31'h0, rsp_err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // word store then word load
        w0 = we_cnt;
        do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'h1122_3344, rd, er, lat);
        chk("sw_lat", lat, 2);
        chk("sw_err", {31'h0, er}, 32'h0);
        chk("sw_we_pulses", we_cnt - w0, 1);
        chk("sw_mem", mem[8'h40], 32'h1122_3344);
        w0 = we_cnt;
        do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, rd, er, lat);
        chk("lw_data", rd, 32'h1122_3344);
        chk("lw_lat", lat, 2);
        chk("lw_err", {31'h0, er}, 32'h0);
        chk("lw_no_we", we_cnt - w0, 0);

        // byte store and byte loads
        w0 = we_cnt;
        do_req(1'b1, 2'b00, 1'b0, 32'h101, 32'hFFFF_FFAB, rd, er, lat);
        chk("sb_lat", lat, 3);
        chk("sb_rdata", rd, 32'h0);
        chk("sb_we_pulses", we_cnt - w0, 1);
        chk("sb_mem", mem[8'h40], 32'h11AB_3344);
        do_req(1'b0, 2'b00, 1'b1, 32'h101, 32'h0, rd, er, lat);
        chk("lb_data", rd, 32'hFFFF_FFAB);
        do_req(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, rd, er, lat);
        chk("lbu_data", rd, 32'h0000_00AB);
        do_req(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, rd, er, lat);
        chk("lbu0_data", rd, 32'h0000_0011);

        // half store and half loads
        do_req(1'b1, 2'b01, 1'b0, 32'h102, 32'h0000_8001, rd, er, lat);
        chk("sh_lat", lat, 3);
        do_req(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, rd, er, lat);
        chk("lh_data", rd, 32'hFFFF_8001);
        chk("lh_lat", lat, 2);
        do_req(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, rd, er, lat);
        chk("lhu_data", rd, 32'h0000_8001);
        do_req(1'b0, 2'b01, 1'b1, 32'h100, 32'h0, rd, er, lat);
        chk("lh0_data", rd, 32'h0000_11AB);
        do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, rd, er, lat);
        chk("lw2_data", rd, 32'h11AB_8001);

        // misaligned and reserved size
        w0 = we_cnt;
        do_req(1'b0, 2'b01, 1'b1, 32'h103, 32'h0, rd, er, lat);
        chk("lh_mis_err", {31'h0, er}, 32'h1);
        chk("lh_mis_lat", lat, 1);
        chk("lh_mis_rdata", rd, 32'h0);
        do_req(1'b1, 2'b10, 1'b0, 32'h102, 32'hCAFE_F00D, rd, er, lat);
        chk("sw_mis_err", {31'h0, er}, 32'h1);
        chk("sw_mis_lat", lat, 1);
        do_req(1'b1, 2'b11, 1'b0, 32'h100, 32'hCAFE_F00D, rd, er, lat);
        chk("rsv_err", {31'h0, er}, 32'h1);
        chk("rsv_rdata", rd, 32'h0);
        chk("mis_no_we", we_cnt - w0, 0);
        chk("mis_mem", mem[8'h40], 32'h11AB_8001);

        // back-to-back loads with req_valid held
        @(negedge clk);
        req_we    = 1'b0;
        req_size  = 2'b10;
        req_addr  = 32'h100;
        req_valid = 1'b1;
        acc  = 0;
        nrsp = 0;
        bad  = 0;
        nlow = 0;
        for (int i = 0; i < 24; i++) begin
            if (!req_ready) nlow++;
            if (req_valid && req_ready) acc++;
            if (rsp_valid) begin
                nrsp++;
                if (req_ready) bad++;
                if (rsp_rdata !== 32'h11AB_8001) bad++;
            end
            if (acc == 4 && req_valid) begin
                @(posedge clk);
                #1 req_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("b2b_accepts", acc, 4);
        chk("b2b_rsp", nrsp, 4);
        chk("b2b_bad", bad, 0);
        chk("b2b_busy_cycles", nlow, 8);

        // reset during RD of a byte store
        w0 = we_cnt;
        r0 = rsp_cnt;
        @(negedge clk);
        req_we    = 1'b1;
        req_size  = 2'b00;
        req_addr  = 32'h100;
        req_wdata = 32'h0000_0055;
        req_valid = 1'b1;
        @(posedge clk);
        #2;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        #1 chk("abort_we_now", {31'h0, MEM_we}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("abort_ready", {31'h0, req_ready}, 32'h1);
        chk("abort_no_we", we_cnt - w0, 0);
        chk("abort_no_rsp", rsp_cnt - r0, 0);
        chk("abort_mem", mem[8'h40], 32'h11AB_8001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
